cordic_trig_iter: RTL and testbench

//  Multi-cycle, parametrised CORDIC sine/cosine engine. IEEE-754 single-precision angle (radians) in,

---
 rtl/cordic_trig_iter.sv | 184 ++++++++++++++++++
 tb/tb_cordic_trig_iter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cordic_trig_iter.sv
// Iterative CORDIC sine/cosine for a float32 angle in radians.
// Performs one micro-rotation per clock and uses a start/done handshake.
module cordic_trig_iter #(
    parameter int WIDTH = 24,
    parameter int ITER  = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        range_err
);
    localparam int DW = WIDTH + 2;
    localparam int SH = 30 - WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_ITER, S_NORM, S_DONE} state_t;

    // Round a 2^-30 scaled constant to WIDTH fraction bits, half-up.
    function automatic logic [63:0] round30(input logic [63:0] c);
        return (c + ((64'd1 << SH) >> 1)) >> SH;
    endfunction

    function automatic logic signed [DW-1:0] atan_fix(input logic [4:0] idx);
        logic [63:0] c;
        case (idx)
            5'd0:    c = 64'd843314857;
            5'd1:    c = 64'd497837829;
            5'd2:    c = 64'd263043837;
            5'd3:    c = 64'd133525159;
            5'd4:    c = 64'd67021687;
            5'd5:    c = 64'd33543516;
            5'd6:    c = 64'd16775851;
            5'd7:    c = 64'd8388437;
            5'd8:    c = 64'd4194283;
            5'd9:    c = 64'd2097149;
            5'd31:   c = 64'd0;
            default: c = 64'd1 << (5'd30 - idx);
        endcase
        return DW'(round30(c));
    endfunction

    localparam logic signed [DW-1:0] K_FIX = DW'(round30(64'd652032874));

    state_t               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic signed [DW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [31:0]          a_q, a_d, result_q, result_d;
    logic                 mode_q, mode_d, rng_q, rng_d, zero_q, zero_d;
    logic                 neg_q, neg_d, range_err_q, range_err_d;

    int                   e_v, sh_v;
    int unsigned          pos_v;
    logic signed [DW-1:0] mag_v, src_v, xs_v, ys_v, at_v;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        a_d         = a_q;
        mode_d      = mode_q;
        rng_d       = rng_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        result_d    = result_q;
        range_err_d = range_err_q;
        e_v         = int'(a_q[30:23]);
        sh_v        = e_v - 150 + WIDTH;
        mag_v       = '0;
        src_v       = mode_q ? y_q : x_q;
        xs_v        = x_q >>> cnt_q;
        ys_v        = y_q >>> cnt_q;
        at_v        = atan_fix(cnt_q[4:0]);
        pos_v       = 0;
        for (int unsigned b = 0; b < DW; b++) begin
            if (z_q[b]) pos_v = b;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = dataa;
                    mode_d  = mode;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (e_v < 128 && e_v != 0 && e_v >= 127 - WIDTH) begin
                    if (sh_v >= 0) mag_v = DW'({40'd0, 1'b1, a_q[22:0]} << sh_v);
                    else           mag_v = DW'({40'd0, 1'b1, a_q[22:0]} >> (-sh_v));
                end
                rng_d   = (e_v >= 128);
                zero_d  = (mag_v == '0);
                z_d     = a_q[31] ? -mag_v : mag_v;
                x_d     = K_FIX;
                y_d     = '0;
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                // Out-of-range requests keep stepping the counter so latency is unchanged.
                if (!rng_q) begin
                    if (!z_q[DW-1]) begin
                        x_d = x_q - ys_v;
                        y_d = y_q + xs_v;
                        z_d = z_q - at_v;
                    end else begin
                        x_d = x_q + ys_v;
                        y_d = y_q - xs_v;
                        z_d = z_q + at_v;
                    end
                end
                if (cnt_q == 6'(ITER - 1)) begin
                    cnt_d   = '0;
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_NORM: begin
                // Two cycles: take the magnitude into z, then leading-one detect and pack.
                if (cnt_q == '0) begin
                    z_d   = src_v[DW-1] ? -src_v : src_v;
                    neg_d = src_v[DW-1];
                    cnt_d = 6'd1;
                end else begin
                    cnt_d       = '0;
                    state_d     = S_DONE;
                    range_err_d = rng_q;
                    if (rng_q)
                        result_d = 32'h7FC0_0000;
                    else if ((mode_q && zero_q) || z_q == '0)
                        result_d = '0;
                    else
                        result_d = {neg_q, 8'(int'(pos_v) + 127 - WIDTH),
                                    23'(({{(64-DW){1'b0}}, z_q} << (63 - pos_v)) >> 40)};
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            a_q         <= '0;
            mode_q      <= 1'b0;
            rng_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            range_err_q <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            a_q         <= a_d;
            mode_q      <= mode_d;
            rng_q       <= rng_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            result_q    <= result_d;
            range_err_q <= range_err_d;
        end
    end

    assign result    = result_q;
    assign range_err = range_err_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_cordic_trig_iter.sv
// Bench for cordic_trig_iter: directed and random angles checked against real-valued $sin/$cos.
module tb_cordic_trig_iter;
    localparam int  W   = 24;
    localparam int  N   = 24;
    localparam int  LAT = N + 3;
    localparam real TOL = 1.0 / 1048576.0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] result;
    logic        done, busy, range_err;

    int checks = 0;
    int errors = 0;

    cordic_trig_iter #(.WIDTH(W), .ITER(N)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start), .mode(mode),
        .dataa(dataa), .result(result), .done(done), .busy(busy), .range_err(range_err)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        int  e;
        real v;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        v = 1.0 + $itor(b[22:0]) / 8388608.0;
        if (e > 127) for (int i = 0; i < e - 127; i++) v = v * 2.0;
        else         for (int i = 0; i < 127 - e; i++) v = v / 2.0;
        return b[31] ? -v : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input real got, input real want);
        logic ok;
        ok = ((got - want) <= TOL) && ((want - got) <= TOL);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed %f expected %f", tag, got, want);
        end
    endtask

    task automatic run_op(input logic m, input logic [31:0] a, input int poke_at,
                          input int stall_len, output logic [31:0] res, output logic rerr,
                          output int lat, output logic seen, output logic busy_ok);
        @(negedge clk);
        for (int g = 0; g < 50 && busy; g++) @(negedge clk);
        start = 1'b1; mode = m; dataa = a;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; dataa = $urandom;
        lat = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && lat < 100) begin
            start = (poke_at != 0 && lat == poke_at);
            if (start) dataa = 32'h3F80_0000;
            if (stall_len > 0 && lat == 8) clk_en = 1'b0;
            if (stall_len > 0 && lat == 8 + stall_len) clk_en = 1'b1;
            @(posedge clk); lat++; #1;
            if (done) seen = 1'b1;
            if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0; clk_en = 1'b1;
        res = result; rerr = range_err;
    endtask

    task automatic check_op(input string tag, input logic m, input logic [31:0] a,
                            input int poke_at, input int stall_len);
        logic [31:0] res;
        logic        rerr, seen, bok;
        int          lat, e;
        real         ang, want;
        run_op(m, a, poke_at, stall_len, res, rerr, lat, seen, bok);
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(LAT + stall_len));
        chk({tag, "_busy"}, 32'(bok), 32'd1);
        e = int'(a[30:23]);
        if (e >= 128) begin
            chk({tag, "_res"}, res, 32'h7FC0_0000);
            chk({tag, "_rng"}, 32'(rerr), 32'd1);
        end else begin
            chk({tag, "_rng"}, 32'(rerr), 32'd0);
            ang  = (e < 127 - W) ? 0.0 : f2r(a);
            want = m ? $sin(ang) : $cos(ang);
            if (m && a[30:0] == 31'd0) chk({tag, "_res"}, res, 32'h0);
            else                        chk_near({tag, "_res"}, f2r(res), want);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic        m, seen;
        int          e;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rng", 32'(range_err), 32'd0);
        @(negedge clk); reset_n = 1'b1;

        check_op("cos_p1", 1'b0, 32'h3F80_0000, 0, 0);
        check_op("cos_m1", 1'b0, 32'hBF80_0000, 0, 0);
        check_op("sin_m1", 1'b1, 32'hBF80_0000, 0, 0);
        check_op("cos_0", 1'b0, 32'h0000_0000, 0, 0);
        check_op("cos_tiny", 1'b0, 32'h3380_0000, 0, 0);
        check_op("sin_0", 1'b1, 32'h0000_0000, 0, 0);
        check_op("sin_half", 1'b1, 32'h3F00_0000, 0, 0);

        // start presented in the done cycle must be dropped
        start = 1'b1; mode = 1'b1; dataa = 32'h3F80_0000;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_cycle_start_busy", 32'(busy), 32'd0);
        chk("done_cycle_start_done", 32'(done), 32'd0);

        check_op("cos_half_poke", 1'b0, 32'h3F00_0000, 5, 0);
        @(posedge clk); #1;
        chk("poke_not_queued", 32'(busy), 32'd0);

        check_op("cos_stall", 1'b0, 32'h3F80_0000, 0, 5);
        check_op("sin_stall", 1'b1, 32'hBF00_0000, 0, 5);

        check_op("rng_two", 1'b0, 32'h4000_0000, 0, 0);
        check_op("rng_inf", 1'b1, 32'h7F80_0000, 0, 0);
        check_op("rng_nan", 1'b0, 32'h7FC0_0000, 0, 0);

        // abort mid-iteration with reset
        @(negedge clk);
        start = 1'b1; mode = 1'b0; dataa = 32'h3F00_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1; reset_n = 1'b0; #1;
        chk("abort_result", result, 32'h0);
        chk("abort_rng", 32'(range_err), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        for (int k = 0; k < 150; k++) begin
            m = 1'($urandom_range(1, 0));
            if (k % 8 == 7) begin
                a = {1'($urandom_range(1, 0)), 1'b1, 30'($urandom)};
            end else begin
                e = int'($urandom_range(127, 95));
                a[31]    = 1'($urandom_range(1, 0));
                a[30:23] = 8'(e);
                a[22:0]  = (e == 127) ? 23'($urandom_range(6207569, 0)) : 23'($urandom);
            end
            check_op($sformatf("rnd%0d", k), m, a, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
